// File: rtl/cu_pkg.sv
// cu_pkg: opcode constants and ALU operation encoding shared by decode and ALU
package cu_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10,
        ALU_SEQ  = 4'd11,
        ALU_SNE  = 4'd12,
        ALU_SGE  = 4'd13,
        ALU_SGEU = 4'd14,
        ALU_NOP  = 4'd15
    } alu_op_e;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode/funct decode into write enable, ALU op and illegal flag
module cu_decode
    import cu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       reg_write,
    output alu_op_e    opsel,
    output logic       illegal
);

    alu_op_e r_op;
    alu_op_e i_op;

    // R-type: only the listed (funct7, funct3) pairs are legal; everything else is NOP
    always_comb begin
        r_op = ALU_NOP;
        case ({funct7, funct3})
            {7'd0, 3'd0}: r_op = ALU_ADD;
            {7'd0, 3'd1}: r_op = ALU_SUB;
            {7'd0, 3'd2}: r_op = ALU_MUL;
            {7'd1, 3'd0}: r_op = ALU_AND;
            {7'd1, 3'd1}: r_op = ALU_OR;
            {7'd1, 3'd2}: r_op = ALU_XOR;
            {7'd1, 3'd3}: r_op = ALU_NOR;
            {7'd2, 3'd0}: r_op = ALU_SLL;
            {7'd2, 3'd1}: r_op = ALU_SRL;
            {7'd3, 3'd0}: r_op = ALU_SLT;
            {7'd3, 3'd1}: r_op = ALU_SLTU;
            {7'd3, 3'd2}: r_op = ALU_SEQ;
            {7'd3, 3'd3}: r_op = ALU_SNE;
            {7'd3, 3'd4}: r_op = ALU_SGE;
            {7'd3, 3'd5}: r_op = ALU_SGEU;
            default:      r_op = ALU_NOP;
        endcase
    end

    // I-type ALU: funct7 is ignored and every funct3 is legal
    always_comb begin
        i_op = ALU_ADD;
        case (funct3)
            3'd0:    i_op = ALU_ADD;
            3'd1:    i_op = ALU_SLL;
            3'd2:    i_op = ALU_SLT;
            3'd3:    i_op = ALU_SLTU;
            3'd4:    i_op = ALU_XOR;
            3'd5:    i_op = ALU_SRL;
            3'd6:    i_op = ALU_OR;
            default: i_op = ALU_AND;
        endcase
    end

    // Select by opcode; an R-type decoding to NOP marks an unsupported pair
    always_comb begin
        opsel     = (opcode == OP_RTYPE) ? r_op : (opcode == OP_ITYPE) ? i_op : ALU_NOP;
        reg_write = (opsel != ALU_NOP);
        illegal   = !reg_write;
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: registered instruction decode aligned to the decode/execute boundary
module control_unit
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       reg_write,
    output logic [3:0] Opsel,
    output logic       illegal
);

    logic    nxt_reg_write;
    alu_op_e nxt_opsel;
    logic    nxt_illegal;

    cu_decode u_decode (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .reg_write (nxt_reg_write),
        .opsel     (nxt_opsel),
        .illegal   (nxt_illegal)
    );

    // Output register; reset parks the pipeline on a non-writing NOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write <= 1'b0;
            Opsel     <= ALU_NOP;
            illegal   <= 1'b0;
        end else begin
            reg_write <= nxt_reg_write;
            Opsel     <= nxt_opsel;
            illegal   <= nxt_illegal;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard-driven bench for the registered decode control unit
module tb_control_unit;

    typedef struct packed {
        logic       rw;
        logic [3:0] op;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       reg_write;
    logic [3:0] Opsel;
    logic       illegal;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .reg_write (reg_write),
        .Opsel     (Opsel),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference decode built from the encoding tables, not from the RTL structure
    function automatic exp_t model(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        int         cnt[4]  = '{3, 4, 2, 6};
        int         base[4] = '{0, 3, 7, 9};
        logic [3:0] it[8]   = '{4'd0, 4'd7, 4'd9, 4'd10, 4'd5, 4'd8, 4'd4, 4'd3};
        model = '{1'b0, 4'hF, 1'b1};
        if (o == 7'b0110011 && f7 < 7'd4 && int'(f3) < cnt[f7[1:0]])
            model = '{1'b1, 4'(base[f7[1:0]] + int'(f3)), 1'b0};
        else if (o == 7'b0010011)
            model = '{1'b1, it[f3], 1'b0};
    endfunction

    task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        opcode = o;
        funct3 = f3;
        funct7 = f7;
        q.push_back(model(o, f3, f7));
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({reg_write, Opsel, illegal} !== {1'b0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got rw=%b op=%0d ill=%b, expected rw=0 op=15 ill=0", reg_write, Opsel, illegal);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({reg_write, Opsel, illegal} !== {1'b0, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got rw=%b op=%0d ill=%b, expected rw=0 op=15 ill=0", reg_write, Opsel, illegal);
        end
        @(negedge clk);
        apply(7'b0110011, 3'd0, 7'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL reset_release: scoreboard empty");
        end else begin
            e = q.pop_front();
            if ({reg_write, Opsel, illegal} !== e) begin
                errors++;
                $display("FAIL reset_release: got rw=%b op=%0d ill=%b, expected rw=%b op=%0d ill=%b", reg_write, Opsel, illegal, e.rw, e.op, e.ill);
            end
        end
    endtask

    task automatic test_rtype_sweep;
        logic [6:0] f7s[15] = '{7'd0, 7'd0, 7'd0, 7'd1, 7'd1, 7'd1, 7'd1, 7'd2, 7'd2, 7'd3, 7'd3, 7'd3, 7'd3, 7'd3, 7'd3};
        logic [2:0] f3s[15] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        for (int i = 0; i < 15; i++) begin
            apply(7'b0110011, f3s[i], f7s[i]);
            @(posedge clk);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rtype_%0d: scoreboard empty", i);
            end else begin
                e = q.pop_front();
                if ({reg_write, Opsel, illegal} !== {1'b1, 4'(i), 1'b0} || e !== {1'b1, 4'(i), 1'b0}) begin
                    errors++;
                    $display("FAIL rtype_%0d: got rw=%b op=%0d ill=%b, expected rw=1 op=%0d ill=0", i, reg_write, Opsel, illegal, i);
                end
            end
            if (i == 7) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({reg_write, Opsel, illegal} !== {1'b0, 4'hF, 1'b0}) begin
                    errors++;
                    $display("FAIL midstream_reset: got rw=%b op=%0d ill=%b, expected rw=0 op=15 ill=0", reg_write, Opsel, illegal);
                end
                #1 rst = 1'b0;
            end
        end
    endtask

    task automatic test_illegal_rtype;
        logic [6:0] f7s[3] = '{7'd5, 7'd3, 7'd2};
        logic [2:0] f3s[3] = '{3'd4, 3'd6, 3'd2};
        for (int i = 0; i < 3; i++) begin
            apply(7'b0110011, f3s[i], f7s[i]);
            @(posedge clk);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL illegal_rtype_%0d: scoreboard empty", i);
            end else begin
                e = q.pop_front();
                if ({reg_write, Opsel, illegal} !== {1'b0, 4'hF, 1'b1} || e !== {1'b0, 4'hF, 1'b1}) begin
                    errors++;
                    $display("FAIL illegal_rtype_%0d: got rw=%b op=%0d ill=%b, expected rw=0 op=15 ill=1", i, reg_write, Opsel, illegal);
                end
            end
        end
    endtask

    task automatic test_itype;
        logic [3:0] seq[8] = '{4'd0, 4'd7, 4'd9, 4'd10, 4'd5, 4'd8, 4'd4, 4'd3};
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                apply(7'b0010011, 3'(i), r == 0 ? 7'd0 : 7'h7F);
                @(posedge clk);
                #1;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL itype_%0d_%0d: scoreboard empty", r, i);
                end else begin
                    e = q.pop_front();
                    if ({reg_write, Opsel, illegal} !== {1'b1, seq[i], 1'b0} || e !== {1'b1, seq[i], 1'b0}) begin
                        errors++;
                        $display("FAIL itype_%0d_%0d: got rw=%b op=%0d ill=%b, expected rw=1 op=%0d ill=0", r, i, reg_write, Opsel, illegal, seq[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_unsupported;
        apply(7'b0011011, 3'd7, 7'd0);
        @(posedge clk);
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unsupported_opcode: scoreboard empty");
        end else begin
            e = q.pop_front();
            if ({reg_write, Opsel, illegal} !== {1'b0, 4'hF, 1'b1} || e !== {1'b0, 4'hF, 1'b1}) begin
                errors++;
                $display("FAIL unsupported_opcode: got rw=%b op=%0d ill=%b, expected rw=0 op=15 ill=1", reg_write, Opsel, illegal);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [6:0] ops[4] = '{7'b0110011, 7'b0010011, 7'b0011011, 7'b0110111};
        for (int i = 0; i < 40; i++) begin
            apply(ops[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                  (i % 3 == 0) ? 7'($urandom) : 7'($urandom_range(0, 4)));
            @(posedge clk);
            #1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL back_to_back_%0d: scoreboard empty", i);
            end else begin
                e = q.pop_front();
                if ({reg_write, Opsel, illegal} !== e) begin
                    errors++;
                    $display("FAIL back_to_back_%0d: got rw=%b op=%0d ill=%b, expected rw=%b op=%0d ill=%b", i, reg_write, Opsel, illegal, e.rw, e.op, e.ill);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_rtype_sweep;
        test_illegal_rtype;
        test_itype;
        test_unsupported;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
